// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory write arbiter.
// Optional feature macro used by the top: WR_COUNT_EN (adds the wr_count output).
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} arb_state_t;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first valid request at or after ptr, wrapping mod NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   gnt_idx
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mem_write_arbiter.sv
// Round-robin arbiter for the data-memory write port, with a full-memory clear sweep.
// Define WR_COUNT_EN to add the saturating wr_count handshake counter output.
module mem_write_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      clr_start,
    output logic                      clr_done,
    output logic                      busy,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wd
`ifdef WR_COUNT_EN
    ,
    output logic [7:0]                wr_count
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [PTR_W-1:0]  LAST_REQ  = PTR_W'(NUM_REQ - 1);

    arb_state_t         state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic [ADDR_W-1:0]  clr_cnt;
    logic               xfer;
    logic               clr_go;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // A clear request in IDLE pre-empts any grant in the same cycle.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        clr_go    = 1'b0;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_nxt = CLEAR;
                    clr_go    = 1'b1;
                end else if (!reset) begin
                    req_ready = gnt;
                end
            end
            CLEAR:   if (clr_cnt == LAST_ADDR) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign xfer     = |(req_valid & req_ready);
    assign busy     = (state != IDLE);
    assign clr_done = (state == DONE);

    // Write command is registered one cycle ahead, so in CLEAR mem_addr always equals clr_cnt.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            clr_cnt  <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_wd   <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_go) begin
                        mem_we   <= 1'b1;
                        mem_addr <= '0;
                        mem_wd   <= '0;
                    end else if (xfer) begin
                        mem_we   <= 1'b1;
                        mem_addr <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
                        mem_wd   <= req_data[gnt_idx*DATA_W +: DATA_W];
                        rr_ptr   <= (gnt_idx == LAST_REQ) ? '0 : gnt_idx + 1'b1;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    mem_wd  <= '0;
                    if (clr_cnt != LAST_ADDR) begin
                        mem_we   <= 1'b1;
                        mem_addr <= clr_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef WR_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset || clr_go)
            wr_count <= '0;
        else if (xfer && wr_count != 8'hFF)
            wr_count <= wr_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Directed-vector bench for mem_write_arbiter (4 requesters, 16-entry memory, 8-bit data).
module tb_mem_write_arbiter;

    localparam int NR = 4;
    localparam int AW = 4;
    localparam int DW = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             clr_start;
    logic             clr_done;
    logic             busy;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wd;
`ifdef WR_COUNT_EN
    logic [7:0]       wr_count;
`endif

    int vectors    = 0;
    int miscompares = 0;

    mem_write_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .clr_start (clr_start),
        .clr_done  (clr_done),
        .busy      (busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd)
`ifdef WR_COUNT_EN
        ,
        .wr_count  (wr_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic check_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        check({tag, "_we"},   32'(mem_we),   32'd1);
        check({tag, "_addr"}, 32'(mem_addr), 32'(a));
        check({tag, "_wd"},   32'(mem_wd),   32'(d));
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        clr_start = 1'b0;
        tick();
        tick();

        // Reset state; ready must stay low while reset is high even with a valid request.
        req_valid = 4'b0001;
        #1;
        check("rst_ready",    32'(req_ready), 32'd0);
        check("rst_we",       32'(mem_we),    32'd0);
        check("rst_addr",     32'(mem_addr),  32'd0);
        check("rst_wd",       32'(mem_wd),    32'd0);
        check("rst_busy",     32'(busy),      32'd0);
        check("rst_clr_done", 32'(clr_done),  32'd0);
        req_valid = '0;
        tick();
        reset = 1'b0;

        // 1: single request, one-cycle latency to the memory write.
        set_req(0, 4'd3, 8'hA5);
        req_valid = 4'b0001;
        #1;
        check("t1_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        check_write("t1", 4'd3, 8'hA5);
        #1;
        check("t1_idle_ready", 32'(req_ready), 32'd0);
        tick();
        check("t1_idle_we", 32'(mem_we), 32'd0);

        // 2: pointer back to 0 via reset, then all four requesting.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, AW'(4 + i), DW'(8'h10 + i));
        req_valid = 4'b1111;
        for (int k = 0; k < NR; k++) begin
            #1;
            check($sformatf("t2_ready%0d", k), 32'(req_ready), 32'(1 << k));
            tick();
            check_write($sformatf("t2_w%0d", k), AW'(4 + k), DW'(8'h10 + k));
        end
        req_valid = '0;
        tick();

        // 3: grant 2, then {0,2} valid: pointer at 3 wraps to 0, then 2.
        req_valid = 4'b0100;
        #1;
        check("t3_ready_a", 32'(req_ready), 32'b0100);
        tick();
        check_write("t3_a", 4'd6, 8'h12);
        req_valid = 4'b0101;
        #1;
        check("t3_ready_b", 32'(req_ready), 32'b0001);
        tick();
        check_write("t3_b", 4'd4, 8'h10);
        req_valid = 4'b0100;
        #1;
        check("t3_ready_c", 32'(req_ready), 32'b0100);
        tick();
        check_write("t3_c", 4'd6, 8'h12);
        req_valid = '0;
        tick();

        // 4: clear wins over a simultaneous request; a re-pulse mid-sweep is ignored.
        req_valid = 4'b0010;
        clr_start = 1'b1;
        #1;
        check("t4_ready_start", 32'(req_ready), 32'd0);
        tick();
        clr_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            #1;
            check_write($sformatf("t4_clr%0d", k), AW'(k), 8'h00);
            check($sformatf("t4_busy%0d", k),  32'(busy),      32'd1);
            check($sformatf("t4_ready%0d", k), 32'(req_ready), 32'd0);
            if (k == 5) clr_start = 1'b1;
            tick();
            clr_start = 1'b0;
        end
        check("t4_done",       32'(clr_done),  32'd1);
        check("t4_done_we",    32'(mem_we),    32'd0);
        check("t4_done_busy",  32'(busy),      32'd1);
        check("t4_done_ready", 32'(req_ready), 32'd0);
        tick();
        check("t4_idle_done", 32'(clr_done),  32'd0);
        check("t4_idle_busy", 32'(busy),      32'd0);
        check("t4_ready1",    32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        check_write("t4_post", 4'd5, 8'h11);
        tick();

        // 5: reset at sweep address 7, then a fresh sweep starts at 0.
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        check_write("t5_at7", 4'd7, 8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst_we",   32'(mem_we),   32'd0);
        check("t5_rst_busy", 32'(busy),     32'd0);
        check("t5_rst_addr", 32'(mem_addr), 32'd0);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        check_write("t5_restart", 4'd0, 8'h00);
        check("t5_restart_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 16; k++) tick();
        check("t5_done", 32'(clr_done), 32'd1);
        tick();
        check("t5_idle_busy", 32'(busy), 32'd0);

`ifdef WR_COUNT_EN
        // 6: counter saturates at 255 and is cleared on entry to CLEAR.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_cnt_rst", 32'(wr_count), 32'd0);
        req_valid = 4'b0001;
        for (int k = 0; k < 10; k++) tick();
        check("t6_cnt10", 32'(wr_count), 32'd10);
        for (int k = 0; k < 290; k++) tick();
        req_valid = '0;
        check("t6_cnt_sat", 32'(wr_count), 32'd255);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        check("t6_cnt_clr", 32'(wr_count), 32'd0);
        for (int k = 0; k < 18; k++) tick();
        check("t6_cnt_after_sweep", 32'(wr_count), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
